// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
// Op codes, ALU operation selects, control bundle and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_OR  = 2'b01;
    localparam logic [1:0] ALU_ADD = 2'b10;
    localparam logic [1:0] ALU_SLT = 2'b11;

    typedef struct packed {
        logic       inv_a;
        logic       inv_b;
        logic [1:0] operation;
    } alu_ctrl_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } fsm_state_t;

    // Only adder results can carry a meaningful overflow.
    function automatic logic ovf_qualifies(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Op-code decoder: maps a 4-bit op onto ALU invert/operation controls.
// Unknown codes decode as AND and raise illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] in_op,
    output alu_ctrl_t  ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl.inv_a     = 1'b0;
        ctrl.inv_b     = 1'b0;
        ctrl.operation = ALU_AND;
        illegal        = 1'b0;
        unique case (1'b1)
            (in_op == OP_AND): ;
            (in_op == OP_OR):
                ctrl.operation = ALU_OR;
            (in_op == OP_ADD):
                ctrl.operation = ALU_ADD;
            (in_op == OP_SUB): begin
                ctrl.inv_b     = 1'b1;
                ctrl.operation = ALU_ADD;
            end
            (in_op == OP_SLT): begin
                ctrl.inv_b     = 1'b1;
                ctrl.operation = ALU_SLT;
            end
            (in_op == OP_NOR): begin
                ctrl.inv_a = 1'b1;
                ctrl.inv_b = 1'b1;
            end
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-stage issue/retire front end for the external ripple ALU.
// Define ALU_OVF_TRAP_EN to stall issue on overflow until trap_ack.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    output logic             alu_invert_a,
    output logic             alu_invert_b,
    output logic [1:0]       alu_operation,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_overflow,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] ovf_count,
    output logic             trap,
    input  logic             trap_ack
);

    alu_ctrl_t        dec_ctrl;
    logic             dec_illegal;

    logic             s1_valid;
    alu_ctrl_t        s1_ctrl;
    logic [31:0]      s1_a;
    logic [31:0]      s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_illegal;
    logic             s1_ovf_en;

    fsm_state_t       state_q;
    logic             run;
    logic             s2_load;
    logic             s1_adv;
    logic             accept;
    logic             qual_ovf;

    alu_op_decode u_dec (
        .in_op   (in_op),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    assign run      = (state_q == RUN);
    assign s2_load  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_load && run;
    assign in_ready = (!s1_valid || s1_adv) && run;
    assign accept   = in_valid && in_ready;
    assign qual_ovf = alu_overflow && s1_ovf_en;

    assign alu_src1      = s1_a;
    assign alu_src2      = s1_b;
    assign alu_invert_a  = s1_ctrl.inv_a;
    assign alu_invert_b  = s1_ctrl.inv_b;
    assign alu_operation = s1_ctrl.operation;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_ctrl    <= '0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_tag     <= '0;
            s1_illegal <= 1'b0;
            s1_ovf_en  <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_ctrl    <= dec_ctrl;
            s1_a       <= in_a;
            s1_b       <= in_b;
            s1_tag     <= in_tag;
            s1_illegal <= dec_illegal;
            s1_ovf_en  <= ovf_qualifies(in_op);
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Illegal ops retire as a zero result with zero flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
        end else if (s1_adv) begin
            out_valid    <= 1'b1;
            out_result   <= s1_illegal ? '0 : alu_result;
            out_zero     <= s1_illegal | alu_zero;
            out_overflow <= qual_ovf;
            out_illegal  <= s1_illegal;
            out_tag      <= s1_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (s1_adv && qual_ovf && (ovf_count != '1)) begin
            ovf_count <= ovf_count + CNT_W'(1);
        end
    end

`ifdef ALU_OVF_TRAP_EN
    fsm_state_t state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:  if (s1_adv && qual_ovf) state_d = TRAP;
            TRAP: if (trap_ack) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign trap = (state_q == TRAP);
`else
    logic unused_trap_ack;

    assign state_q         = RUN;
    assign trap            = 1'b0;
    assign unused_trap_ack = trap_ack;
`endif

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-stage front end that feeds the 32-bit ripple ALU and retires its results. Accepts ALU requests over a valid/ready handshake and decodes a 4-bit op code into the ALU's invert-A, invert-B and 2-bit operation controls. Holds the operands in a stage register that drives the external ALU combinationally, then captures result, zero and qualified overflow into an output register with its own valid/ready. It also keeps a saturating overflow counter.

## Interface
- TAG_W, 4, width of the request tag carried alongside each op
- CNT_W, 16, width of the saturating overflow counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1  request handshake
- in_op  in  4  op code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR; all other codes are illegal
- in_a, in_b  in  32  operands
- in_tag  in  TAG_W  request tag
- alu_src1, alu_src2  out  32  operands to the ALU
- alu_invert_a, alu_invert_b  out  1  ALU invert controls
- alu_operation  out  2  ALU operation select
- alu_result  in  32  ALU result, combinational from the alu_* outputs
- alu_zero, alu_overflow  in  1  ALU flags
- out_valid / out_ready  out / in  1  result handshake
- out_result  out  32; out_zero, out_overflow, out_illegal  out  1; out_tag  out  TAG_W
- ovf_count  out  CNT_W  saturating count of qualified overflows
- trap, trap_ack  out / in  1  only with ALU_OVF_TRAP_EN; otherwise trap is tied to 0 and trap_ack is ignored

## Operation
- Decode {inv_a, inv_b, operation}: AND {0,0,00}; OR {0,0,01}; ADD {0,0,10}; SUB {0,1,10}; SLT {0,1,11}; NOR {1,1,00}.
- Illegal op: decode as AND. At S2 capture, force the result to 0 and zero to 1, and set out_illegal to 1.
- S1 (issue register): holds s1_valid, the decoded controls, the operands and the tag. The alu_* outputs are driven directly from S1 flops.
- S2 (output register): captures alu_result, alu_zero, the qualified overflow, the illegal flag and the tag when S1 advances.
- Qualified overflow = alu_overflow AND (op is ADD or SUB). Any overflow the ALU reports for SLT is masked.
- S2 can load when !out_valid || out_ready.
- S1 advances when s1_valid && S2 can load && FSM is RUN.
- in_ready = (!s1_valid || S1 advances) && FSM is RUN. This gives full throughput with one op per cycle.
- ovf_count increments by 1 on each S1 advance with qualified overflow. It saturates at all-ones and never wraps.
- FSM states are RUN and TRAP. TRAP is reachable only with ALU_OVF_TRAP_EN.

## Timing
- Reset values:
  - s1_valid = 0, alu_src1 = alu_src2 = 0, alu_invert_a = alu_invert_b = 0, alu_operation = 00.
  - out_valid = 0, out_result = 0, out_zero = 0, out_overflow = 0, out_illegal = 0, out_tag = 0.
  - ovf_count = 0, trap = 0, FSM = RUN.
  - in_ready = 1 in the first cycle after reset release.
- Latency: a request accepted at edge N drives the ALU during cycle N..N+1. out_valid is asserted after edge N+1.
- Back-pressure: while out_valid && !out_ready, S2 holds, S1 holds, and in_ready drops once S1 is full. No request is lost or duplicated.
- Simultaneous out_ready and in_valid with both stages full: S2 retires, S1 moves to S2, and the new request enters S1 at the same edge.
- out_* and alu_* outputs are stable while their stage is stalled.
- Reset asserted mid-operation: all in-flight ops are discarded and all outputs immediately take their reset values.

## Configuration
- ALU_OVF_TRAP_EN defined:
  - An S1 advance with qualified overflow still writes S2 normally.
  - The FSM moves to TRAP and trap is asserted from the next cycle.
  - In TRAP, in_ready = 0 and S1 does not advance; S2 may still drain.
  - A trap_ack high for one cycle returns the FSM to RUN and clears trap at that edge.
  - trap_ack while in RUN is ignored.
- ALU_OVF_TRAP_EN undefined: there is no TRAP state, trap is tied to 0, and overflow only sets out_overflow and increments ovf_count.

## Structure
- Shared package alu_pkg holds:
  - the op-code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR);
  - the 2-bit ALU operation constants;
  - an alu_ctrl_t struct {inv_a, inv_b, operation}.
- One sub-module, alu_op_decode: combinational, in_op in, alu_ctrl_t plus illegal out.
- The FSM and the counter stay in the top module.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, out_ready = 1: out_result = 0x80000000 and out_overflow = 1 two cycles after accept; ovf_count = 1.
- SLT with a = 0xFFFFFFFF, b = 0x00000001: ALU controls are {0,1,11}; out_result = 1 and out_overflow = 0.
- Back-to-back stream of 8 SUBs with out_ready low for cycles 3–6: every tag appears exactly once and in order; in_ready drops while both stages are full.
- Illegal op code 5 with a = b = 0x1234: out_result = 0, out_zero = 1, out_illegal = 1, and the tag is preserved.
- With ALU_OVF_TRAP_EN, SUB 0x80000000 − 1: trap = 1 and in_ready stays 0 until a trap_ack pulse, after which a queued AND request completes.
- Assert rst_n low while both stages are full: out_valid = 0 and ovf_count = 0 immediately; in_ready = 1 after release.
